hazard_mc: RTL and testbench



---
 rtl/hazard_mc_if.sv | 49 ++++
 rtl/hazard_mc.sv | 123 ++++++++++++
 tb/tb_hazard_mc.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_mc_if.sv
// Pipeline <-> hazard controller signal bundle.
// The pipeline side uses the master modport and drives stage information.
// The hazard controller uses the slave modport and returns forwarding selects,
// stalls, flushes and divider handshakes.
interface hazard_mc_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  // Decode stage
  logic [REG_AW-1:0] rsD, rtD;
  logic              branchD, jrD;
  // Execute stage
  logic [REG_AW-1:0] rsE, rtE, writeregE;
  logic              regwriteE, memtoregE, div_reqE;
  // Memory / writeback stages
  logic [REG_AW-1:0] writeregM, writeregW;
  logic              regwriteM, memtoregM, regwriteW;
  // HI/LO write enables
  logic [1:0]        hilo_weE, hilo_weM, hilo_weW;
  // Divider, memory waits, exceptions, perf counter
  logic              div_ready, i_stall, d_stall, except_flushM, perf_clr;
  // Results
  logic              forwardaD, forwardbD;
  logic [1:0]        forwardaE, forwardbE, forwardhiloE;
  logic              div_start, div_cancel, div_busy;
  logic              stallF, stallD, stallE, stallM, stallW;
  logic              flushD, flushE, flushM, flushW;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output rsD, rtD, branchD, jrD, rsE, rtE, writeregE, regwriteE, memtoregE,
           div_reqE, writeregM, regwriteM, memtoregM, writeregW, regwriteW,
           hilo_weE, hilo_weM, hilo_weW, div_ready, i_stall, d_stall,
           except_flushM, perf_clr,
    input  forwardaD, forwardbD, forwardaE, forwardbE, forwardhiloE,
           div_start, div_cancel, div_busy, stallF, stallD, stallE, stallM,
           stallW, flushD, flushE, flushM, flushW, stall_cnt
  );

  modport slave (
    input  rsD, rtD, branchD, jrD, rsE, rtE, writeregE, regwriteE, memtoregE,
           div_reqE, writeregM, regwriteM, memtoregM, writeregW, regwriteW,
           hilo_weE, hilo_weM, hilo_weW, div_ready, i_stall, d_stall,
           except_flushM, perf_clr,
    output forwardaD, forwardbD, forwardaE, forwardbE, forwardhiloE,
           div_start, div_cancel, div_busy, stallF, stallD, stallE, stallM,
           stallW, flushD, flushE, flushM, flushW, stall_cnt
  );
endinterface

// File: rtl/hazard_mc.sv
// Five-stage MIPS hazard controller: GPR and HI/LO forwarding, load-use and
// branch stalls, divider handshake FSM, exception flush, memory wait stalls
// and a saturating stall-cycle counter.
module hazard_mc #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input logic     clk,
  input logic     resetn,
  hazard_mc_if.slave hz
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} divState_t;

  divState_t        divState;
  logic [CNT_W-1:0] stallCount;

  logic lwStall, brStall, memStall, divStall, divStartNow;
  logic stallEInt, stallFInt;
  logic rsMatchE, rtMatchE, rsMatchM, rtMatchM;

  // Source operand matches against E and M destinations (register 0 never hazards)
  always_comb begin
    rsMatchE = (hz.writeregE != '0) && (hz.writeregE == hz.rsD);
    rtMatchE = (hz.writeregE != '0) && (hz.writeregE == hz.rtD);
    rsMatchM = (hz.writeregM != '0) && (hz.writeregM == hz.rsD);
    rtMatchM = (hz.writeregM != '0) && (hz.writeregM == hz.rtD);
  end

  // Forwarding selects: D-stage from M only; E-stage with M beating W
  always_comb begin
    hz.forwardaD = (hz.rsD != '0) && (hz.rsD == hz.writeregM) && hz.regwriteM;
    hz.forwardbD = (hz.rtD != '0) && (hz.rtD == hz.writeregM) && hz.regwriteM;

    hz.forwardaE = 2'b00;
    if (hz.rsE != '0) begin
      if (hz.regwriteM && hz.rsE == hz.writeregM)      hz.forwardaE = 2'b10;
      else if (hz.regwriteW && hz.rsE == hz.writeregW) hz.forwardaE = 2'b01;
    end

    hz.forwardbE = 2'b00;
    if (hz.rtE != '0) begin
      if (hz.regwriteM && hz.rtE == hz.writeregM)      hz.forwardbE = 2'b10;
      else if (hz.regwriteW && hz.rtE == hz.writeregW) hz.forwardbE = 2'b01;
    end

    // An instruction in E that writes HI/LO itself needs no forwarded value
    hz.forwardhiloE = 2'b00;
    if (hz.hilo_weE == 2'b00) begin
      if (hz.hilo_weM != 2'b00)      hz.forwardhiloE = 2'b01;
      else if (hz.hilo_weW != 2'b00) hz.forwardhiloE = 2'b10;
    end
  end

  // Hazard conditions and divider handshake decode
  always_comb begin
    lwStall  = hz.memtoregE && (rsMatchE || rtMatchE);
    brStall  = (hz.branchD || hz.jrD) &&
               ((hz.regwriteE && (rsMatchE || rtMatchE)) ||
                (hz.memtoregM && (rsMatchM || rtMatchM)));
    memStall = hz.i_stall || hz.d_stall;
    // div_ready during the start cycle is deliberately not looked at in IDLE
    divStall    = ((divState == IDLE) && hz.div_reqE) ||
                  ((divState == BUSY) && !hz.div_ready);
    divStartNow = (divState == IDLE) && hz.div_reqE && !hz.except_flushM;
    hz.div_start  = divStartNow;
    hz.div_cancel = hz.except_flushM && ((divState == BUSY) || divStartNow);
    hz.div_busy   = (divState != IDLE);
  end

  // Stall/flush composition: exception, memory wait, divider, load/branch
  always_comb begin
    hz.stallF = 1'b0; hz.stallD = 1'b0; hz.stallE = 1'b0;
    hz.stallM = 1'b0; hz.stallW = 1'b0;
    hz.flushD = 1'b0; hz.flushE = 1'b0; hz.flushM = 1'b0; hz.flushW = 1'b0;
    if (hz.except_flushM) begin
      hz.flushD = 1'b1; hz.flushE = 1'b1; hz.flushM = 1'b1; hz.flushW = 1'b1;
      hz.stallF = hz.i_stall;
    end else if (memStall) begin
      hz.stallF = 1'b1; hz.stallD = 1'b1; hz.stallE = 1'b1;
      hz.stallM = 1'b1; hz.stallW = 1'b1;
    end else if (divStall) begin
      hz.stallF = 1'b1; hz.stallD = 1'b1; hz.stallE = 1'b1;
      hz.flushM = 1'b1;
    end else if (lwStall || brStall) begin
      hz.stallF = 1'b1; hz.stallD = 1'b1;
      hz.flushE = 1'b1;
    end
    stallEInt = hz.stallE;
    stallFInt = hz.stallF;
  end

  // Divider FSM: DONE holds off a restart while the finished DIV is still stuck in E
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      divState <= IDLE;
    end else if (hz.except_flushM) begin
      divState <= IDLE;
    end else begin
      case (divState)
        IDLE: if (hz.div_reqE) divState <= BUSY;
        BUSY: if (hz.div_ready)
                divState <= (memStall || lwStall || brStall) ? DONE : IDLE;
        DONE: if (!stallEInt) divState <= IDLE;
        default: divState <= IDLE;
      endcase
    end
  end

  // Saturating stall-cycle counter; clear beats increment
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stallCount <= '0;
    end else if (hz.perf_clr) begin
      stallCount <= '0;
    end else if (stallFInt && !hz.except_flushM && (stallCount != '1)) begin
      stallCount <= stallCount + 1'b1;
    end
  end

  assign hz.stall_cnt = stallCount;

endmodule

// File: tb/tb_hazard_mc.sv
// Directed testbench for hazard_mc: one task per scenario with inline checks.
module tb_hazard_mc;

  logic clk;
  logic resetn;
  int   total;
  int   bad;

  hazard_mc_if #(.REG_AW(5), .CNT_W(4)) hz ();

  hazard_mc #(.REG_AW(5), .CNT_W(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .hz     (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {stallF,stallD,stallE,stallM,stallW,flushD,flushE,flushM,flushW}
  function automatic logic [8:0] ctlVec();
    return {hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.stallW,
            hz.flushD, hz.flushE, hz.flushM, hz.flushW};
  endfunction

  task automatic idleInputs();
    hz.rsD = '0; hz.rtD = '0; hz.branchD = 1'b0; hz.jrD = 1'b0;
    hz.rsE = '0; hz.rtE = '0; hz.writeregE = '0;
    hz.regwriteE = 1'b0; hz.memtoregE = 1'b0; hz.div_reqE = 1'b0;
    hz.writeregM = '0; hz.regwriteM = 1'b0; hz.memtoregM = 1'b0;
    hz.writeregW = '0; hz.regwriteW = 1'b0;
    hz.hilo_weE = 2'b00; hz.hilo_weM = 2'b00; hz.hilo_weW = 2'b00;
    hz.div_ready = 1'b0; hz.i_stall = 1'b0; hz.d_stall = 1'b0;
    hz.except_flushM = 1'b0; hz.perf_clr = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idleInputs();
    resetn = 1'b0;
    #12;
    total++;
    if ({ctlVec(), hz.forwardaD, hz.forwardbD, hz.forwardaE, hz.forwardbE, hz.forwardhiloE,
         hz.div_start, hz.div_cancel, hz.div_busy} !== 20'd0) begin
      bad++; $display("FAIL reset_outputs got ctl=%b busy=%b exp all zero", ctlVec(), hz.div_busy);
    end
    total++;
    if (hz.stall_cnt !== 4'd0) begin
      bad++; $display("FAIL reset_cnt got=%0d exp=0", hz.stall_cnt);
    end
    @(negedge clk);
    resetn = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_load_use();
    idleInputs();
    hz.memtoregE = 1'b1; hz.writeregE = 5'd8; hz.rsD = 5'd8;
    #1;
    total++;
    if (ctlVec() !== 9'b11000_0100) begin
      bad++; $display("FAIL load_use got=%b exp=%b", ctlVec(), 9'b110000100);
    end
    hz.writeregE = 5'd0; hz.rsD = 5'd0;
    #1;
    total++;
    if (ctlVec() !== 9'd0) begin
      bad++; $display("FAIL load_use_r0 got=%b exp=0", ctlVec());
    end
    // rt match also triggers
    hz.writeregE = 5'd9; hz.rtD = 5'd9;
    #1;
    total++;
    if (ctlVec() !== 9'b11000_0100) begin
      bad++; $display("FAIL load_use_rt got=%b exp=%b", ctlVec(), 9'b110000100);
    end
    $display("test_load_use done");
  endtask

  task automatic test_branch();
    idleInputs();
    hz.branchD = 1'b1; hz.rsD = 5'd3; hz.regwriteE = 1'b1; hz.writeregE = 5'd3;
    #1;
    total++;
    if (ctlVec() !== 9'b11000_0100) begin
      bad++; $display("FAIL br_stall_E got=%b exp=%b", ctlVec(), 9'b110000100);
    end
    idleInputs();
    hz.jrD = 1'b1; hz.rtD = 5'd4; hz.memtoregM = 1'b1; hz.writeregM = 5'd4;
    #1;
    total++;
    if (ctlVec() !== 9'b11000_0100) begin
      bad++; $display("FAIL br_stall_M got=%b exp=%b", ctlVec(), 9'b110000100);
    end
    // ALU result in M is forwarded to D instead of stalling
    hz.memtoregM = 1'b0; hz.regwriteM = 1'b1;
    #1;
    total++;
    if ({ctlVec(), hz.forwardaD, hz.forwardbD} !== 11'b00000_0000_01) begin
      bad++; $display("FAIL br_fwd_D got=%b fa=%b fb=%b exp ctl=0 fa=0 fb=1",
                      ctlVec(), hz.forwardaD, hz.forwardbD);
    end
    $display("test_branch done");
  endtask

  task automatic test_forward();
    idleInputs();
    hz.rsE = 5'd5; hz.writeregM = 5'd5; hz.writeregW = 5'd5;
    hz.regwriteM = 1'b1; hz.regwriteW = 1'b1;
    #1;
    total++;
    if (hz.forwardaE !== 2'b10) begin
      bad++; $display("FAIL fwdA_M got=%b exp=10", hz.forwardaE);
    end
    hz.regwriteM = 1'b0;
    #1;
    total++;
    if (hz.forwardaE !== 2'b01) begin
      bad++; $display("FAIL fwdA_W got=%b exp=01", hz.forwardaE);
    end
    hz.rsE = 5'd0; hz.writeregW = 5'd0; hz.rtE = 5'd6; hz.writeregM = 5'd6; hz.regwriteM = 1'b1;
    #1;
    total++;
    if ({hz.forwardaE, hz.forwardbE} !== 4'b0010) begin
      bad++; $display("FAIL fwd_r0_rt got a=%b b=%b exp a=00 b=10", hz.forwardaE, hz.forwardbE);
    end
    hz.hilo_weM = 2'b01; hz.hilo_weW = 2'b10;
    #1;
    total++;
    if (hz.forwardhiloE !== 2'b01) begin
      bad++; $display("FAIL fwd_hilo_M got=%b exp=01", hz.forwardhiloE);
    end
    hz.hilo_weM = 2'b00;
    #1;
    total++;
    if (hz.forwardhiloE !== 2'b10) begin
      bad++; $display("FAIL fwd_hilo_W got=%b exp=10", hz.forwardhiloE);
    end
    hz.hilo_weE = 2'b11;
    #1;
    total++;
    if (hz.forwardhiloE !== 2'b00) begin
      bad++; $display("FAIL fwd_hilo_selfwrite got=%b exp=00", hz.forwardhiloE);
    end
    $display("test_forward done");
  endtask

  task automatic test_div();
    int starts, stallEs, flushMs;
    starts = 0; stallEs = 0; flushMs = 0;
    idleInputs();
    hz.div_reqE = 1'b1;
    for (int c = 0; c < 8; c++) begin
      hz.div_ready = (c == 7);
      #1;
      starts  += hz.div_start;
      stallEs += hz.stallE;
      flushMs += hz.flushM;
      tick();
    end
    hz.div_ready = 1'b0;
    hz.div_reqE = 1'b0;
    #1;
    total++;
    if (starts !== 1) begin
      bad++; $display("FAIL div_start_count got=%0d exp=1", starts);
    end
    total++;
    if (stallEs !== 7 || flushMs !== 7) begin
      bad++; $display("FAIL div_stall_cycles got stallE=%0d flushM=%0d exp 7/7", stallEs, flushMs);
    end
    total++;
    if (hz.div_busy !== 1'b0 || ctlVec() !== 9'd0) begin
      bad++; $display("FAIL div_end_idle got busy=%b ctl=%b exp 0/0", hz.div_busy, ctlVec());
    end
    $display("test_div done");
  endtask

  task automatic test_div_mem_stall();
    int starts;
    starts = 0;
    idleInputs();
    hz.div_reqE = 1'b1;
    #1;
    starts += hz.div_start;
    tick();
    hz.d_stall = 1'b1; hz.div_ready = 1'b1;
    #1;
    starts += hz.div_start;
    total++;
    if (ctlVec() !== 9'b11111_0000) begin
      bad++; $display("FAIL divmem_ready_ctl got=%b exp=%b", ctlVec(), 9'b111110000);
    end
    tick();
    hz.div_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      starts += hz.div_start;
      total++;
      if (hz.div_busy !== 1'b1 || hz.stallE !== 1'b1) begin
        bad++; $display("FAIL divmem_done_hold got busy=%b stallE=%b exp 1/1", hz.div_busy, hz.stallE);
      end
      tick();
    end
    hz.d_stall = 1'b0;
    #1;
    starts += hz.div_start;
    total++;
    if (ctlVec() !== 9'd0) begin
      bad++; $display("FAIL divmem_release got=%b exp=0", ctlVec());
    end
    tick();
    hz.div_reqE = 1'b0;
    #1;
    total++;
    if (starts !== 1 || hz.div_busy !== 1'b0) begin
      bad++; $display("FAIL divmem_restart got starts=%0d busy=%b exp 1/0", starts, hz.div_busy);
    end
    $display("test_div_mem_stall done");
  endtask

  task automatic test_div_except();
    idleInputs();
    hz.div_reqE = 1'b1;
    tick();
    hz.except_flushM = 1'b1; hz.i_stall = 1'b1;
    #1;
    total++;
    if (hz.div_cancel !== 1'b1 || ctlVec() !== 9'b10000_1111) begin
      bad++; $display("FAIL div_except got cancel=%b ctl=%b exp 1/%b", hz.div_cancel, ctlVec(), 9'b100001111);
    end
    tick();
    hz.except_flushM = 1'b0; hz.i_stall = 1'b0; hz.div_reqE = 1'b0;
    #1;
    total++;
    if (hz.div_busy !== 1'b0 || hz.div_cancel !== 1'b0) begin
      bad++; $display("FAIL div_except_idle got busy=%b cancel=%b exp 0/0", hz.div_busy, hz.div_cancel);
    end
    $display("test_div_except done");
  endtask

  task automatic test_reset_busy();
    idleInputs();
    hz.div_reqE = 1'b1;
    tick();
    hz.div_reqE = 1'b0;
    #1;
    total++;
    if (hz.div_busy !== 1'b1) begin
      bad++; $display("FAIL rstbusy_pre got=%b exp=1", hz.div_busy);
    end
    resetn = 1'b0;
    #1;
    total++;
    if (hz.div_busy !== 1'b0 || hz.div_cancel !== 1'b0) begin
      bad++; $display("FAIL rstbusy_async got busy=%b cancel=%b exp 0/0", hz.div_busy, hz.div_cancel);
    end
    @(negedge clk);
    resetn = 1'b1;
    tick();
    $display("test_reset_busy done");
  endtask

  task automatic test_counter();
    idleInputs();
    hz.perf_clr = 1'b1;
    tick();
    hz.perf_clr = 1'b0;
    #1;
    total++;
    if (hz.stall_cnt !== 4'd0) begin
      bad++; $display("FAIL cnt_clr0 got=%0d exp=0", hz.stall_cnt);
    end
    hz.memtoregE = 1'b1; hz.writeregE = 5'd8; hz.rsD = 5'd8;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 4) begin
        total++;
        if (hz.stall_cnt !== 4'd5) begin
          bad++; $display("FAIL cnt_mid got=%0d exp=5", hz.stall_cnt);
        end
      end
    end
    total++;
    if (hz.stall_cnt !== 4'd15) begin
      bad++; $display("FAIL cnt_sat got=%0d exp=15", hz.stall_cnt);
    end
    hz.perf_clr = 1'b1;
    tick();
    hz.perf_clr = 1'b0;
    #1;
    total++;
    if (hz.stall_cnt !== 4'd0) begin
      bad++; $display("FAIL cnt_clr_override got=%0d exp=0", hz.stall_cnt);
    end
    idleInputs();
    hz.except_flushM = 1'b1; hz.i_stall = 1'b1;
    tick();
    hz.except_flushM = 1'b0;
    tick();
    total++;
    if (hz.stall_cnt !== 4'd1) begin
      bad++; $display("FAIL cnt_except got=%0d exp=1", hz.stall_cnt);
    end
    idleInputs();
    $display("test_counter done");
  endtask

  initial begin
    total = 0;
    bad = 0;
    resetn = 1'b0;
    test_reset();
    test_load_use();
    test_branch();
    test_forward();
    test_counter();
    test_div();
    test_div_mem_stall();
    test_div_except();
    test_reset_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
